// File: rtl/tri_pkg.sv
// Shared definitions for the triangle motion controller.
//   - default active-area and triangle-size parameters
//   - FSM state and config-field encodings
//   - reset anchors and velocities for the R/G/B shapes (index 0/1/2)
package tri_pkg;

    localparam int H_ACT_DEF = 1280;
    localparam int V_ACT_DEF = 1024;
    localparam int SIZE_DEF  = 300;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_UPD0,
        ST_UPD1,
        ST_UPD2,
        ST_COMMIT
    } state_e;

    typedef enum logic [1:0] {
        FLD_POS_X = 2'd0,
        FLD_POS_Y = 2'd1,
        FLD_VEL_X = 2'd2,
        FLD_VEL_Y = 2'd3
    } cfg_field_e;

    // Packed arrays: element [0] is R, [1] is G, [2] is B.
    localparam logic [2:0][10:0] RST_POS_X = {11'd500, 11'd400, 11'd400};
    localparam logic [2:0][10:0] RST_POS_Y = {11'd600, 11'd600, 11'd500};
    // Velocities are 8-bit two's complement: R=(+2,+1) G=(-1,+2) B=(+1,-1)
    localparam logic [2:0][7:0]  RST_VEL_X = {8'h01, 8'hFF, 8'h02};
    localparam logic [2:0][7:0]  RST_VEL_Y = {8'hFF, 8'h02, 8'h01};

endpackage

// File: rtl/tri_bounce_axis.sv
// One-axis bounce step (combinational).
//   pos_i   : current anchor (unsigned)
//   vel_i   : signed step per frame
//   limit_i : largest legal anchor
//   pos_o   : anchor after the step, clamped to 0..limit_i
//   vel_o   : velocity after the step, reversed when an edge is hit
module tri_bounce_axis (
    input  logic [10:0] pos_i,
    input  logic [7:0]  vel_i,
    input  logic [10:0] limit_i,
    output logic [10:0] pos_o,
    output logic [7:0]  vel_o
);

    logic signed [12:0] sum;
    logic [7:0]         vel_neg;

    assign sum = $signed({2'b00, pos_i}) + $signed({{5{vel_i[7]}}, vel_i});

    // -128 has no positive counterpart in 8 bits; saturate to +127.
    assign vel_neg = (vel_i == 8'h80) ? 8'h7F : (~vel_i + 8'd1);

    always_comb begin
        pos_o = sum[10:0];
        vel_o = vel_i;
        if (sum < 13'sd0) begin
            pos_o = '0;
            vel_o = vel_neg;
        end else if (sum > $signed({2'b00, limit_i})) begin
            pos_o = limit_i;
            vel_o = vel_neg;
        end
    end

endmodule

// File: rtl/tri_motion_ctrl.sv
// Per-frame motion controller for the R/G/B triangle anchors.
// Working positions advance by their velocities once per frame (one shape
// per cycle) and are copied to the display registers in a single COMMIT
// cycle during blanking.
//   VGA_CLK, reset         : pixel clock, synchronous active-high reset
//   disp_en, x, y          : timing generator, used to find frame end
//   pause                  : hold motion; commit still publishes
//   cfg_valid/ready/sel/field/data : host write port into working regs
//   px0..px2, py0..py2     : published anchors
//   frame_tick             : one-cycle pulse when anchors are published
//
// state     | meaning
// ----------+----------------------------------------------
// ST_IDLE   | wait for frame end; host writes accepted
// ST_UPD0   | step shape 0 (R)
// ST_UPD1   | step shape 1 (G)
// ST_UPD2   | step shape 2 (B)
// ST_COMMIT | copy working positions to display registers
module tri_motion_ctrl
    import tri_pkg::*;
#(
    parameter int H_ACT = H_ACT_DEF,
    parameter int V_ACT = V_ACT_DEF,
    parameter int SIZE  = SIZE_DEF
) (
    input  logic        VGA_CLK,
    input  logic        reset,
    input  logic        disp_en,
    input  logic [10:0] x,
    input  logic [10:0] y,
    input  logic        pause,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic [1:0]  cfg_sel,
    input  logic [1:0]  cfg_field,
    input  logic [10:0] cfg_data,
    output logic [10:0] px0,
    output logic [10:0] py0,
    output logic [10:0] px1,
    output logic [10:0] py1,
    output logic [10:0] px2,
    output logic [10:0] py2,
    output logic        frame_tick
);

    localparam logic [10:0] LIM_X   = 11'(H_ACT - SIZE);
    localparam logic [10:0] LIM_Y   = 11'(V_ACT - SIZE);
    localparam logic [10:0] LAST_X  = 11'(H_ACT - 1);
    localparam logic [10:0] LAST_Y  = 11'(V_ACT - 1);

    state_e             state_q, state_d;
    logic [2:0][10:0]   pos_x_q, pos_x_d, pos_y_q, pos_y_d;
    logic [2:0][7:0]    vel_x_q, vel_x_d, vel_y_q, vel_y_d;
    logic [2:0][10:0]   disp_x_q, disp_y_q;
    logic               cfg_ready_q;
    logic               frame_tick_q;

    logic               frame_end;
    logic               cfg_fire;
    logic               upd_en;
    logic [1:0]         upd_idx;
    logic               commit;

    logic [10:0]        cur_pos_x, cur_pos_y, nxt_pos_x, nxt_pos_y;
    logic [7:0]         cur_vel_x, cur_vel_y, nxt_vel_x, nxt_vel_y;

    assign frame_end = disp_en && (x == LAST_X) && (y == LAST_Y);
    assign cfg_fire  = cfg_valid && cfg_ready_q;

    always_comb begin
        state_d = state_q;
        upd_en  = 1'b0;
        upd_idx = 2'd0;
        commit  = 1'b0;
        case (state_q)
            ST_IDLE:   if (frame_end) state_d = ST_UPD0;
            ST_UPD0: begin
                upd_en  = 1'b1;
                upd_idx = 2'd0;
                state_d = ST_UPD1;
            end
            ST_UPD1: begin
                upd_en  = 1'b1;
                upd_idx = 2'd1;
                state_d = ST_UPD2;
            end
            ST_UPD2: begin
                upd_en  = 1'b1;
                upd_idx = 2'd2;
                state_d = ST_COMMIT;
            end
            ST_COMMIT: begin
                commit  = 1'b1;
                state_d = ST_IDLE;
            end
            default:   state_d = ST_IDLE;
        endcase
    end

    // Select the shape being stepped this cycle.
    always_comb begin
        cur_pos_x = pos_x_q[0];
        cur_pos_y = pos_y_q[0];
        cur_vel_x = vel_x_q[0];
        cur_vel_y = vel_y_q[0];
        for (int k = 1; k < 3; k++) begin
            if (upd_idx == 2'(k)) begin
                cur_pos_x = pos_x_q[k];
                cur_pos_y = pos_y_q[k];
                cur_vel_x = vel_x_q[k];
                cur_vel_y = vel_y_q[k];
            end
        end
    end

    tri_bounce_axis u_axis_x (
        .pos_i   (cur_pos_x),
        .vel_i   (cur_vel_x),
        .limit_i (LIM_X),
        .pos_o   (nxt_pos_x),
        .vel_o   (nxt_vel_x)
    );

    tri_bounce_axis u_axis_y (
        .pos_i   (cur_pos_y),
        .vel_i   (cur_vel_y),
        .limit_i (LIM_Y),
        .pos_o   (nxt_pos_y),
        .vel_o   (nxt_vel_y)
    );

    // Host writes only land in IDLE and steps only happen in UPD states,
    // so the two sources never collide on the same register.
    always_comb begin
        pos_x_d = pos_x_q;
        pos_y_d = pos_y_q;
        vel_x_d = vel_x_q;
        vel_y_d = vel_y_q;
        for (int k = 0; k < 3; k++) begin
            if (cfg_fire && (cfg_sel == 2'(k))) begin
                case (cfg_field_e'(cfg_field))
                    FLD_POS_X: pos_x_d[k] = (cfg_data > LIM_X) ? LIM_X : cfg_data;
                    FLD_POS_Y: pos_y_d[k] = (cfg_data > LIM_Y) ? LIM_Y : cfg_data;
                    FLD_VEL_X: vel_x_d[k] = cfg_data[7:0];
                    FLD_VEL_Y: vel_y_d[k] = cfg_data[7:0];
                    default:   ;
                endcase
            end
            if (upd_en && !pause && (upd_idx == 2'(k))) begin
                pos_x_d[k] = nxt_pos_x;
                pos_y_d[k] = nxt_pos_y;
                vel_x_d[k] = nxt_vel_x;
                vel_y_d[k] = nxt_vel_y;
            end
        end
    end

    always_ff @(posedge VGA_CLK) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            pos_x_q      <= RST_POS_X;
            pos_y_q      <= RST_POS_Y;
            vel_x_q      <= RST_VEL_X;
            vel_y_q      <= RST_VEL_Y;
            disp_x_q     <= RST_POS_X;
            disp_y_q     <= RST_POS_Y;
            cfg_ready_q  <= 1'b0;
            frame_tick_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pos_x_q      <= pos_x_d;
            pos_y_q      <= pos_y_d;
            vel_x_q      <= vel_x_d;
            vel_y_q      <= vel_y_d;
            cfg_ready_q  <= (state_d == ST_IDLE);
            frame_tick_q <= commit;
            if (commit) begin
                disp_x_q <= pos_x_q;
                disp_y_q <= pos_y_q;
            end
        end
    end

    assign cfg_ready  = cfg_ready_q;
    assign frame_tick = frame_tick_q;
    assign px0        = disp_x_q[0];
    assign py0        = disp_y_q[0];
    assign px1        = disp_x_q[1];
    assign py1        = disp_y_q[1];
    assign px2        = disp_x_q[2];
    assign py2        = disp_y_q[2];

endmodule

// File: tb/tb_tri_motion_ctrl.sv
// Scoreboard bench for tri_motion_ctrl: stimulus pushes the expected
// published anchors and arrival cycle; a monitor pops on every frame_tick.
module tb_tri_motion_ctrl;

    localparam int H  = 1280;
    localparam int V  = 1024;
    localparam int S  = 300;
    localparam int LX = H - S;
    localparam int LY = V - S;

    logic        VGA_CLK = 1'b0;
    logic        reset;
    logic        disp_en;
    logic [10:0] x, y;
    logic        pause;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [1:0]  cfg_sel, cfg_field;
    logic [10:0] cfg_data;
    logic [10:0] px0, py0, px1, py1, px2, py2;
    logic        frame_tick;

    tri_motion_ctrl #(.H_ACT(H), .V_ACT(V), .SIZE(S)) dut (
        .VGA_CLK    (VGA_CLK),
        .reset      (reset),
        .disp_en    (disp_en),
        .x          (x),
        .y          (y),
        .pause      (pause),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_sel    (cfg_sel),
        .cfg_field  (cfg_field),
        .cfg_data   (cfg_data),
        .px0        (px0),
        .py0        (py0),
        .px1        (px1),
        .py1        (py1),
        .px2        (px2),
        .py2        (py2),
        .frame_tick (frame_tick)
    );

    always #5 VGA_CLK = ~VGA_CLK;

    int cyc = 0;
    always @(posedge VGA_CLK) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [2:0][10:0] px;
        logic [2:0][10:0] py;
        int               at;
    } exp_t;

    exp_t sb[$];

    // Reference model: plain integer anchors and velocities.
    int mpx[3], mpy[3], mvx[3], mvy[3];

    task automatic chk(input string nm, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    function automatic void model_reset();
        mpx = '{400, 400, 500};
        mpy = '{500, 600, 600};
        mvx = '{2, -1, 1};
        mvy = '{1, 2, -1};
    endfunction

    function automatic int neg_sat(input int v);
        return (v == -128) ? 127 : -v;
    endfunction

    function automatic void bounce(input int p, input int v, input int lim,
                                   output int np, output int nv);
        int s;
        s = p + v;
        if (s < 0) begin
            np = 0;
            nv = neg_sat(v);
        end else if (s > lim) begin
            np = lim;
            nv = neg_sat(v);
        end else begin
            np = s;
            nv = v;
        end
    endfunction

    function automatic void model_write(input int sel, input int fld, input logic [10:0] data);
        logic signed [7:0] v8;
        int d;
        v8 = data[7:0];
        d  = int'(data);
        if (sel > 2) return;
        case (fld)
            0: mpx[sel] = (d > LX) ? LX : d;
            1: mpy[sel] = (d > LY) ? LY : d;
            2: mvx[sel] = int'(v8);
            default: mvy[sel] = int'(v8);
        endcase
    endfunction

    function automatic void model_frame(input bit pz, input int at);
        exp_t e;
        int np, nv;
        if (!pz) begin
            for (int k = 0; k < 3; k++) begin
                bounce(mpx[k], mvx[k], LX, np, nv);
                mpx[k] = np; mvx[k] = nv;
                bounce(mpy[k], mvy[k], LY, np, nv);
                mpy[k] = np; mvy[k] = nv;
            end
        end
        for (int k = 0; k < 3; k++) begin
            e.px[k] = 11'(mpx[k]);
            e.py[k] = 11'(mpy[k]);
        end
        e.at = at;
        sb.push_back(e);
    endfunction

    // Monitor: every frame_tick must match the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge VGA_CLK);
            if (frame_tick === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("unexpected_frame_tick", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("tick_cycle", cyc, e.at);
                    chk("px0", int'(px0), int'(e.px[0]));
                    chk("py0", int'(py0), int'(e.py[0]));
                    chk("px1", int'(px1), int'(e.px[1]));
                    chk("py1", int'(py1), int'(e.py[1]));
                    chk("px2", int'(px2), int'(e.px[2]));
                    chk("py2", int'(py2), int'(e.py[2]));
                end
            end
        end
    end

    task automatic chk_reset_outputs();
        chk("rst_px0", int'(px0), 400);
        chk("rst_py0", int'(py0), 500);
        chk("rst_px1", int'(px1), 400);
        chk("rst_py1", int'(py1), 600);
        chk("rst_px2", int'(px2), 500);
        chk("rst_py2", int'(py2), 600);
        chk("rst_frame_tick", int'(frame_tick), 0);
        chk("rst_cfg_ready", int'(cfg_ready), 0);
    endtask

    task automatic cfg_write(input logic [1:0] sel, input logic [1:0] fld, input logic [10:0] d);
        int n;
        @(negedge VGA_CLK);
        cfg_valid = 1'b1;
        cfg_sel   = sel;
        cfg_field = fld;
        cfg_data  = d;
        n = 0;
        while (cfg_ready !== 1'b1 && n < 20) begin
            @(negedge VGA_CLK);
            n++;
        end
        if (n >= 20) begin
            chk("cfg_ready_timeout", 0, 1);
        end else begin
            model_write(int'(sel), int'(fld), d);
        end
        @(negedge VGA_CLK);
        cfg_valid = 1'b0;
    endtask

    // Frame end pulse, optionally with a simultaneous write; checks the
    // cfg_ready low window T+1..T+4 and high at T+5.
    task automatic frame(input bit pz, input bit wr,
                         input logic [1:0] sel, input logic [1:0] fld, input logic [10:0] d);
        int c;
        @(negedge VGA_CLK);
        chk("ready_before_frame", int'(cfg_ready), 1);
        pause   = pz;
        disp_en = 1'b1;
        x       = 11'(H - 1);
        y       = 11'(V - 1);
        if (wr) begin
            cfg_valid = 1'b1;
            cfg_sel   = sel;
            cfg_field = fld;
            cfg_data  = d;
            model_write(int'(sel), int'(fld), d);
        end
        c = cyc;
        model_frame(pz, c + 5);
        @(negedge VGA_CLK);
        disp_en   = 1'b0;
        x         = '0;
        y         = '0;
        cfg_valid = 1'b0;
        chk("ready_low_upd0", int'(cfg_ready), 0);
        for (int k = 2; k <= 4; k++) begin
            @(negedge VGA_CLK);
            chk("ready_low_seq", int'(cfg_ready), 0);
        end
        @(negedge VGA_CLK);
        chk("ready_high_t5", int'(cfg_ready), 1);
        pause = 1'b0;
        @(negedge VGA_CLK);
    endtask

    initial begin
        int c;
        int n;
        reset     = 1'b1;
        disp_en   = 1'b0;
        x         = '0;
        y         = '0;
        pause     = 1'b0;
        cfg_valid = 1'b0;
        cfg_sel   = '0;
        cfg_field = '0;
        cfg_data  = '0;
        model_reset();

        repeat (3) @(negedge VGA_CLK);
        chk_reset_outputs();
        reset = 1'b0;
        @(negedge VGA_CLK);
        chk("ready_after_release", int'(cfg_ready), 1);

        // Plain motion from reset values.
        frame(1'b0, 1'b0, 2'd0, 2'd0, 11'd0);

        // Right-edge bounce of R.
        cfg_write(2'd0, 2'd0, 11'd979);
        cfg_write(2'd0, 2'd2, 11'd5);
        frame(1'b0, 1'b0, 2'd0, 2'd0, 11'd0);
        frame(1'b0, 1'b0, 2'd0, 2'd0, 11'd0);

        // Top-edge bounce of G with negative velocity.
        cfg_write(2'd1, 2'd1, 11'd1);
        cfg_write(2'd1, 2'd3, 11'h0FD);
        frame(1'b0, 1'b0, 2'd0, 2'd0, 11'd0);
        frame(1'b0, 1'b0, 2'd0, 2'd0, 11'd0);

        // Paused frame still publishes the written position.
        cfg_write(2'd2, 2'd0, 11'd10);
        frame(1'b1, 1'b0, 2'd0, 2'd0, 11'd0);

        // Write coinciding with frame end, clamped position.
        frame(1'b0, 1'b1, 2'd1, 2'd0, 11'd2000);

        // -128 velocity with upper bits set; negation saturates.
        cfg_write(2'd0, 2'd0, 11'd1);
        cfg_write(2'd0, 2'd2, 11'h780);
        frame(1'b0, 1'b0, 2'd0, 2'd0, 11'd0);
        frame(1'b0, 1'b0, 2'd0, 2'd0, 11'd0);

        // Shape select 3 handshakes but changes nothing.
        cfg_write(2'd3, 2'd0, 11'd7);
        frame(1'b0, 1'b0, 2'd0, 2'd0, 11'd0);

        // cfg_valid held from UPD1: stalls until T+5, applied after commit.
        @(negedge VGA_CLK);
        disp_en = 1'b1;
        x       = 11'(H - 1);
        y       = 11'(V - 1);
        c       = cyc;
        model_frame(1'b0, c + 5);
        @(negedge VGA_CLK);
        disp_en = 1'b0;
        x       = '0;
        y       = '0;
        @(negedge VGA_CLK);
        cfg_valid = 1'b1;
        cfg_sel   = 2'd0;
        cfg_field = 2'd0;
        cfg_data  = 11'd123;
        chk("held_ready_upd1", int'(cfg_ready), 0);
        @(negedge VGA_CLK);
        chk("held_ready_upd2", int'(cfg_ready), 0);
        @(negedge VGA_CLK);
        chk("held_ready_commit", int'(cfg_ready), 0);
        @(negedge VGA_CLK);
        chk("held_ready_t5", int'(cfg_ready), 1);
        model_write(0, 0, 11'd123);
        @(negedge VGA_CLK);
        cfg_valid = 1'b0;
        frame(1'b0, 1'b0, 2'd0, 2'd0, 11'd0);

        // Reset during UPD1 abandons the update with no tick.
        @(negedge VGA_CLK);
        disp_en = 1'b1;
        x       = 11'(H - 1);
        y       = 11'(V - 1);
        @(negedge VGA_CLK);
        disp_en = 1'b0;
        x       = '0;
        y       = '0;
        @(negedge VGA_CLK);
        reset = 1'b1;
        @(negedge VGA_CLK);
        chk_reset_outputs();
        @(negedge VGA_CLK);
        chk_reset_outputs();
        reset = 1'b0;
        model_reset();
        @(negedge VGA_CLK);
        chk("ready_after_midreset", int'(cfg_ready), 1);
        repeat (6) @(negedge VGA_CLK);
        frame(1'b0, 1'b0, 2'd0, 2'd0, 11'd0);

        // Randomised writes and frames.
        for (int it = 0; it < 25; it++) begin
            n = int'($urandom_range(0, 3));
            for (int w = 0; w < n; w++) begin
                cfg_write(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                          11'($urandom_range(0, 2047)));
            end
            frame(($urandom_range(0, 5) == 0), 1'b0, 2'd0, 2'd0, 11'd0);
        end

        n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(negedge VGA_CLK);
            n++;
        end
        chk("scoreboard_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
